hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised forwarding and hazard-detection unit for the 5-stage pipeline, replacing the combinational bypass selector. It produces operand-forwarding selects for rs, rt and store data from three producer stages: EX/MEM, MEM/WB and WB. It also owns load-use stalls, with a configurable load latency, and a multi-cycle multiply/divide busy interlock. It sits beside the ID/EX boundary and drives the IF/ID stall and ID/EX flush controls.

## Interface
- REG_AW, 5, register-address width
- LOAD_LAT, 1, load-use bubbles required (1..3)
- MD_LAT, 4, multiply/divide busy cycles after issue (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  ID instruction valid
- id_rs, id_rt  in  REG_AW  ID source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_alusrc  in  1  ALU B takes immediate
- id_is_store  in  1  ID instruction is sw
- id_md_start  in  1  ID instruction issues mult/div
- id_reads_hilo  in  1  ID instruction reads HI/LO
- ex_rd, mem_rd, wb_rd  in  REG_AW  destination of instruction in that stage
- ex_regwrite, mem_regwrite, wb_regwrite  in  1  stage writes register file
- ex_memread  in  1  EX instruction is a load
- fwd_a, fwd_b, fwd_store  out  2  operand selects
- stall_if, stall_id  out  1  hold PC / IF-ID register
- flush_ex  out  1  insert bubble into ID/EX
- md_busy  out  1  multiply/divide unit occupied

## Operation
- Select encoding: 00 register file, 10 EX/MEM, 01 MEM/WB, 11 WB.
- Priority: EX > MEM > WB. A stage matches only when its regwrite is 1 and its rd is nonzero.
- fwd_a is driven from id_rs when id_uses_rs is 1; otherwise it is 00.
- fwd_b is driven from id_rt when id_uses_rt is 1 and id_alusrc is 0; otherwise it is 00.
- fwd_store is driven from id_rt when id_is_store is 1, regardless of id_alusrc.
- All selects are forced to 00 when id_valid is 0.
- Load hazard (combinational): id_valid & ex_memread & ex_regwrite & ex_rd≠0 & (ex_rd matches a used source, or the store rt).
- MD hazard: id_valid & md_busy & (id_reads_hilo | id_md_start).
- Load FSM states are RUN and LD_WAIT.
  - RUN: on a load hazard with LOAD_LAT>1, go to LD_WAIT with ld_cnt=LOAD_LAT-1.
  - LD_WAIT: decrement ld_cnt each cycle; return to RUN when ld_cnt reaches 1 on an edge.
- stall = load_hazard | (state==LD_WAIT) | md_hazard.
- stall_if, stall_id and flush_ex all equal stall.
- MD counter: id_md_start & id_valid & ~stall loads md_cnt=MD_LAT at the edge.
  - md_busy = (md_cnt≠0).
  - md_cnt decrements each cycle while nonzero.
  - A stalled md_start does not load the counter.
- Simultaneous load and MD hazards: a single stall is asserted, and the FSM and counter advance independently.
- Reset: while rst=0, all outputs are forced to 0. At the edge, state becomes RUN and ld_cnt and md_cnt become 0. Reset asserted mid-stall abandons the stall.

## Timing
- Forward selects and the hazard term are combinational from the current stage inputs, with zero latency.
- Reset value of every output is 0, with fwd_* = 00.
- Load-use stall length is exactly LOAD_LAT cycles, counted from the cycle the hazard is first visible.
- md_busy rises in the cycle after the issuing edge and stays high for exactly MD_LAT cycles.
- When LOAD_LAT=1, the FSM never leaves RUN.
- An ld_cnt or md_cnt value at zero never decrements (no wrap).

## Structure
- The package hazard_pkg holds:
  - FWD_RF, FWD_EXM, FWD_MWB and FWD_WB constants;
  - the load-FSM state enum (RUN, LD_WAIT);
  - the counter-width localparams.
- Sub-module fwd_sel performs the priority compare of one source address against the three stages. It is instantiated three times: for rs, for rt (ALU) and for rt (store).

## Test plan
- id_rs=3, id_uses_rs=1, ex_rd=3 with ex_regwrite=1, mem_rd=3 → fwd_a=10; the same case with ex_regwrite=0 → fwd_a=01.
- id_rt=0 and ex_rd=0 with regwrite=1 → fwd_b=00. id_alusrc=1, id_is_store=1, mem_rd=id_rt=7 → fwd_b=00 and fwd_store=01.
- Load-use with LOAD_LAT=2: ex_memread=1, ex_rd=id_rs=4 → stall and flush_ex high for exactly 2 cycles, then 0.
- MD_LAT=4: an mfhi reaches ID one cycle after mult issues → stall for 3 cycles; md_busy falls 4 cycles after issue.
- Load hazard coincident with md_busy → a single continuous stall of max(remaining) cycles.
- rst=0 during LD_WAIT → outputs 0 immediately; after release, state is RUN and md_busy=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select codes, load-FSM states and counter widths
package hazard_pkg;
   typedef logic [1:0] fwd_t;
   localparam fwd_t FWD_RF  = 2'b00;
   localparam fwd_t FWD_EXM = 2'b10;
   localparam fwd_t FWD_MWB = 2'b01;
   localparam fwd_t FWD_WB  = 2'b11;
   typedef enum logic {RUN, LD_WAIT} ld_state_e;
   localparam int LD_CW = 2;
   localparam int MD_CW = 4;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side stage info in, forwarding/stall controls out
interface hazard_unit_if #(parameter int REG_AW = 5);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs, id_rt;
   logic              id_uses_rs, id_uses_rt, id_alusrc, id_is_store;
   logic              id_md_start, id_reads_hilo;
   logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
   logic              ex_regwrite, mem_regwrite, wb_regwrite, ex_memread;
   logic [1:0]        fwd_a, fwd_b, fwd_store;
   logic              stall_if, stall_id, flush_ex, md_busy;
   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_alusrc, id_is_store,
             id_md_start, id_reads_hilo, ex_rd, mem_rd, wb_rd,
             ex_regwrite, mem_regwrite, wb_regwrite, ex_memread,
      input  fwd_a, fwd_b, fwd_store, stall_if, stall_id, flush_ex, md_busy
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_alusrc, id_is_store,
             id_md_start, id_reads_hilo, ex_rd, mem_rd, wb_rd,
             ex_regwrite, mem_regwrite, wb_regwrite, ex_memread,
      output fwd_a, fwd_b, fwd_store, stall_if, stall_id, flush_ex, md_busy
   );
endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// fwd_sel: priority match of one source register against EX/MEM, MEM/WB and WB
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              en_i,
   input  logic [REG_AW-1:0] src_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_we_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              mem_we_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_we_i,
   output fwd_t              sel_o
);
   logic ex_hit, mem_hit, wb_hit;
   assign ex_hit  = ex_we_i  & (ex_rd_i  != '0) & (ex_rd_i  == src_i);
   assign mem_hit = mem_we_i & (mem_rd_i != '0) & (mem_rd_i == src_i);
   assign wb_hit  = wb_we_i  & (wb_rd_i  != '0) & (wb_rd_i  == src_i);
   assign sel_o = !en_i   ? FWD_RF  :
                  ex_hit  ? FWD_EXM :
                  mem_hit ? FWD_MWB :
                  wb_hit  ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding, load-use stall FSM and mult/div busy interlock
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 4
) (
   input logic         clk,
   input logic         rst,
   hazard_unit_if.slave hu
);
   ld_state_e        state_q, state_d;
   logic [LD_CW-1:0] ld_cnt_q, ld_cnt_d;
   logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
   logic             ok, load_hazard, md_hazard, md_busy, stall, ld_match;
   // rst is active-low: every output is gated while it is held low
   assign ok = rst & hu.id_valid;
   fwd_sel #(.REG_AW(REG_AW)) u_rs (
      .en_i(ok & hu.id_uses_rs), .src_i(hu.id_rs),
      .ex_rd_i(hu.ex_rd), .ex_we_i(hu.ex_regwrite),
      .mem_rd_i(hu.mem_rd), .mem_we_i(hu.mem_regwrite),
      .wb_rd_i(hu.wb_rd), .wb_we_i(hu.wb_regwrite),
      .sel_o(hu.fwd_a)
   );
   fwd_sel #(.REG_AW(REG_AW)) u_rt (
      .en_i(ok & hu.id_uses_rt & ~hu.id_alusrc), .src_i(hu.id_rt),
      .ex_rd_i(hu.ex_rd), .ex_we_i(hu.ex_regwrite),
      .mem_rd_i(hu.mem_rd), .mem_we_i(hu.mem_regwrite),
      .wb_rd_i(hu.wb_rd), .wb_we_i(hu.wb_regwrite),
      .sel_o(hu.fwd_b)
   );
   fwd_sel #(.REG_AW(REG_AW)) u_st (
      .en_i(ok & hu.id_is_store), .src_i(hu.id_rt),
      .ex_rd_i(hu.ex_rd), .ex_we_i(hu.ex_regwrite),
      .mem_rd_i(hu.mem_rd), .mem_we_i(hu.mem_regwrite),
      .wb_rd_i(hu.wb_rd), .wb_we_i(hu.wb_regwrite),
      .sel_o(hu.fwd_store)
   );
   assign ld_match = (hu.id_uses_rs & (hu.id_rs == hu.ex_rd)) |
                     ((hu.id_uses_rt | hu.id_is_store) & (hu.id_rt == hu.ex_rd));
   assign load_hazard = ok & hu.ex_memread & hu.ex_regwrite & (hu.ex_rd != '0) & ld_match;
   assign md_busy     = rst & (md_cnt_q != '0);
   assign md_hazard   = ok & md_busy & (hu.id_reads_hilo | hu.id_md_start);
   assign stall       = load_hazard | (rst & (state_q == LD_WAIT)) | md_hazard;
   assign hu.stall_if = stall;
   assign hu.stall_id = stall;
   assign hu.flush_ex = stall;
   assign hu.md_busy  = md_busy;
   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      if (state_q == RUN) begin
         if (load_hazard && LOAD_LAT > 1) begin
            state_d  = LD_WAIT;
            ld_cnt_d = LD_CW'(LOAD_LAT - 1);
         end
      end else begin
         ld_cnt_d = (ld_cnt_q != '0) ? ld_cnt_q - LD_CW'(1) : ld_cnt_q;
         state_d  = (ld_cnt_q <= LD_CW'(1)) ? RUN : LD_WAIT;
      end
   end
   // a stalled md_start is not an issue, so it must not reload the counter
   assign md_cnt_d = (ok & hu.id_md_start & ~stall) ? MD_CW'(MD_LAT) :
                     (md_cnt_q != '0)               ? md_cnt_q - MD_CW'(1) : md_cnt_q;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= RUN;
         ld_cnt_q <= '0;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         md_cnt_q <= md_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit with LOAD_LAT=2, MD_LAT=4
module tb_hazard_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_asrt = 0;
   int   n_fail = 0;
   logic [9:0] sb[$];
   always #5 clk = ~clk;
   hazard_unit_if #(.REG_AW(5)) hif ();
   hazard_unit #(.REG_AW(5), .LOAD_LAT(2), .MD_LAT(4)) dut (.clk(clk), .rst(rst), .hu(hif));
   wire [9:0] act = {hif.fwd_a, hif.fwd_b, hif.fwd_store, hif.stall_if, hif.stall_id,
                     hif.flush_ex, hif.md_busy};
   function automatic logic [9:0] e(input logic [1:0] a, b, s, input logic st, mb);
      return {a, b, s, st, st, st, mb};
   endfunction
   task automatic idle();
      hif.id_valid = 0; hif.id_rs = 0; hif.id_rt = 0; hif.id_uses_rs = 0; hif.id_uses_rt = 0;
      hif.id_alusrc = 0; hif.id_is_store = 0; hif.id_md_start = 0; hif.id_reads_hilo = 0;
      hif.ex_rd = 0; hif.mem_rd = 0; hif.wb_rd = 0; hif.ex_regwrite = 0; hif.mem_regwrite = 0;
      hif.wb_regwrite = 0; hif.ex_memread = 0;
   endtask
   task automatic test_reset();
      logic [9:0] got, want;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         idle();
         rst = (i == 3);
         if (i < 3) begin
            hif.id_valid = 1; hif.id_rs = 3; hif.id_uses_rs = 1; hif.ex_rd = 3;
            hif.ex_regwrite = 1; hif.ex_memread = 1; hif.id_reads_hilo = 1;
         end
         sb.push_back(e(0, 0, 0, 0, 0));
         @(negedge clk);
         got = act; want = sb.pop_front(); n_asrt++;
         if (got !== want) begin
            n_fail++; $display("FAIL reset[%0d]: got %b expected %b", i, got, want);
         end
      end
   endtask
   task automatic test_fwd();
      logic [9:0] got, want;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         idle();
         hif.id_valid = 1;
         case (i)
            0, 1: begin
               hif.id_rs = 3; hif.id_uses_rs = 1; hif.ex_rd = 3; hif.ex_regwrite = (i == 0);
               hif.mem_rd = 3; hif.mem_regwrite = 1;
               sb.push_back(e(i == 0 ? 2'b10 : 2'b01, 0, 0, 0, 0));
            end
            2: begin
               hif.id_rt = 0; hif.id_uses_rt = 1; hif.ex_rd = 0; hif.ex_regwrite = 1;
               sb.push_back(e(0, 0, 0, 0, 0));
            end
            3: begin
               hif.id_rt = 7; hif.id_uses_rt = 1; hif.id_alusrc = 1; hif.id_is_store = 1;
               hif.mem_rd = 7; hif.mem_regwrite = 1;
               sb.push_back(e(0, 0, 2'b01, 0, 0));
            end
            4: begin
               hif.id_rs = 5; hif.id_uses_rs = 1; hif.wb_rd = 5; hif.wb_regwrite = 1;
               sb.push_back(e(2'b11, 0, 0, 0, 0));
            end
            5: begin
               hif.id_valid = 0; hif.id_rs = 5; hif.id_uses_rs = 1; hif.ex_rd = 5;
               hif.ex_regwrite = 1;
               sb.push_back(e(0, 0, 0, 0, 0));
            end
            6: begin
               hif.id_rs = 9; hif.ex_rd = 9; hif.ex_regwrite = 1;
               sb.push_back(e(0, 0, 0, 0, 0));
            end
            default: begin
               hif.id_rt = 6; hif.id_uses_rt = 1; hif.mem_rd = 6; hif.mem_regwrite = 1;
               hif.wb_rd = 6; hif.wb_regwrite = 1;
               sb.push_back(e(0, 2'b01, 0, 0, 0));
            end
         endcase
         @(negedge clk);
         got = act; want = sb.pop_front(); n_asrt++;
         if (got !== want) begin
            n_fail++; $display("FAIL fwd[%0d]: got %b expected %b", i, got, want);
         end
      end
   endtask
   task automatic test_load_use();
      logic [9:0] got, want;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         idle();
         hif.id_valid = 1; hif.id_rs = 4; hif.id_uses_rs = 1;
         if (i == 0) begin
            hif.ex_rd = 4; hif.ex_regwrite = 1; hif.ex_memread = 1;
         end
         if (i >= 2) begin
            hif.mem_rd = 4; hif.mem_regwrite = 1;
         end
         sb.push_back(i == 0 ? e(2'b10, 0, 0, 1, 0) : i == 1 ? e(0, 0, 0, 1, 0) :
                      e(2'b01, 0, 0, 0, 0));
         @(negedge clk);
         got = act; want = sb.pop_front(); n_asrt++;
         if (got !== want) begin
            n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, want);
         end
      end
   endtask
   task automatic test_store_load();
      logic [9:0] got, want;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         idle();
         hif.id_valid = 1;
         if (i < 3) begin
            hif.id_rt = 8; hif.id_is_store = 1; hif.id_alusrc = 1;
         end
         if (i == 0) begin
            hif.ex_rd = 8; hif.ex_regwrite = 1; hif.ex_memread = 1;
         end
         if (i == 2) begin
            hif.mem_rd = 8; hif.mem_regwrite = 1;
         end
         if (i == 3) begin
            hif.id_uses_rs = 1; hif.ex_regwrite = 1; hif.ex_memread = 1;
         end
         sb.push_back(i == 0 ? e(0, 0, 2'b10, 1, 0) : i == 1 ? e(0, 0, 0, 1, 0) :
                      i == 2 ? e(0, 0, 2'b01, 0, 0) : e(0, 0, 0, 0, 0));
         @(negedge clk);
         got = act; want = sb.pop_front(); n_asrt++;
         if (got !== want) begin
            n_fail++; $display("FAIL store_load[%0d]: got %b expected %b", i, got, want);
         end
      end
   endtask
   task automatic test_md();
      logic [9:0] got, want;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         idle();
         hif.id_valid = (i < 12);
         hif.id_md_start = (i == 0) || (i >= 6 && i <= 11);
         hif.id_reads_hilo = (i >= 2 && i <= 5);
         sb.push_back((i == 0 || i == 5 || i == 6 || i == 11 || i == 16) ? e(0, 0, 0, 0, 0) :
                      (i == 1 || i >= 12) ? e(0, 0, 0, 0, 1) : e(0, 0, 0, 1, 1));
         @(negedge clk);
         got = act; want = sb.pop_front(); n_asrt++;
         if (got !== want) begin
            n_fail++; $display("FAIL md[%0d]: got %b expected %b", i, got, want);
         end
      end
   endtask
   task automatic test_coincident();
      logic [9:0] got, want;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         idle();
         hif.id_valid = 1;
         hif.id_md_start = (i == 0);
         if (i >= 1) begin
            hif.id_rs = 4; hif.id_uses_rs = 1; hif.id_reads_hilo = 1;
         end
         if (i == 1) begin
            hif.ex_rd = 4; hif.ex_regwrite = 1; hif.ex_memread = 1;
         end
         if (i >= 2) begin
            hif.mem_rd = 4; hif.mem_regwrite = 1;
         end
         sb.push_back(i == 0 ? e(0, 0, 0, 0, 0) : i == 1 ? e(2'b10, 0, 0, 1, 1) :
                      i == 5 ? e(2'b01, 0, 0, 0, 0) : e(2'b01, 0, 0, 1, 1));
         @(negedge clk);
         got = act; want = sb.pop_front(); n_asrt++;
         if (got !== want) begin
            n_fail++; $display("FAIL coincident[%0d]: got %b expected %b", i, got, want);
         end
      end
   endtask
   task automatic test_reset_mid_stall();
      logic [9:0] got, want;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         idle();
         rst = (i != 2);
         hif.id_valid = (i < 4);
         hif.id_md_start = (i == 0);
         if (i >= 1) begin
            hif.id_rs = 4; hif.id_uses_rs = 1; hif.id_reads_hilo = (i >= 2);
         end
         if (i == 1) begin
            hif.ex_rd = 4; hif.ex_regwrite = 1; hif.ex_memread = 1;
         end
         sb.push_back(i == 1 ? e(2'b10, 0, 0, 1, 1) : e(0, 0, 0, 0, 0));
         @(negedge clk);
         got = act; want = sb.pop_front(); n_asrt++;
         if (got !== want) begin
            n_fail++; $display("FAIL reset_mid_stall[%0d]: got %b expected %b", i, got, want);
         end
      end
   endtask
   initial begin
      idle();
      test_reset();
      test_fwd();
      test_load_use();
      test_store_load();
      test_md();
      test_coincident();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
